beep_decoder: RTL

//  Receive-side counterpart of the buzzer tone generator. Measures the period of an incoming

---
 rtl/beep_decoder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/beep_decoder.sv
// Tone period meter and scale-note classifier for the buzzer loopback path.
// Measures rising-edge-to-rising-edge period of beep_in and debounces the note decision.
module beep_decoder #(
    parameter logic [17:0] DO      = 18'd190839,
    parameter logic [17:0] RE      = 18'd170067,
    parameter logic [17:0] MI      = 18'd151514,
    parameter logic [17:0] FA      = 18'd143266,
    parameter logic [17:0] SO      = 18'd127551,
    parameter logic [17:0] LA      = 18'd113636,
    parameter logic [17:0] XI      = 18'd101214,
    parameter logic [17:0] TOL     = 18'd2000,
    parameter logic [24:0] TIMEOUT = 25'd24999999,
    parameter logic [2:0]  STABLE  = 3'd3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        beep_in,
    output logic [17:0] period,
    output logic        period_vld,
    output logic [2:0]  note_code,
    output logic        note_chg,
    output logic        tone_on
);

    localparam logic [17:0] PER_MAX = 18'h3FFFF;

    logic        s1, s2, s3;
    logic        armed;
    logic [17:0] per_cnt;
    logic [24:0] idle_cnt;
    logic [2:0]  last_cand;
    logic [2:0]  match_cnt;
    logic        rise;
    logic        timeout;
    logic [2:0]  cand;
    logic [2:0]  next_match;

    // A saturated counter means "too long to measure" and must never look like a note.
    function automatic logic in_window(input logic [17:0] p, input logic [17:0] note_p);
        logic [17:0] diff;
        diff = (p >= note_p) ? (p - note_p) : (note_p - p);
        return (p != PER_MAX) && (diff <= TOL);
    endfunction

    assign rise    = s2 & ~s3;
    assign timeout = ~rise & (idle_cnt == TIMEOUT);

    // Classify the last period, lowest note code wins, then compute the next stability count.
    always_comb begin
        cand = 3'd0;
        if (in_window(period, DO)) begin
            cand = 3'd1;
        end else if (in_window(period, RE)) begin
            cand = 3'd2;
        end else if (in_window(period, MI)) begin
            cand = 3'd3;
        end else if (in_window(period, FA)) begin
            cand = 3'd4;
        end else if (in_window(period, SO)) begin
            cand = 3'd5;
        end else if (in_window(period, LA)) begin
            cand = 3'd6;
        end else if (in_window(period, XI)) begin
            cand = 3'd7;
        end else begin
            cand = 3'd0;
        end

        next_match = 3'd1;
        if (cand == last_cand) begin
            next_match = (match_cnt >= STABLE) ? STABLE : (match_cnt + 3'd1);
        end else begin
            next_match = 3'd1;
        end
    end

    // Input synchroniser, period measurement, silence timeout and note debouncing.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            armed      <= 1'b0;
            per_cnt    <= 18'd0;
            idle_cnt   <= 25'd0;
            last_cand  <= 3'd0;
            match_cnt  <= 3'd0;
            period     <= 18'd0;
            period_vld <= 1'b0;
            note_code  <= 3'd0;
            note_chg   <= 1'b0;
            tone_on    <= 1'b0;
        end else begin
            s1         <= beep_in;
            s2         <= s1;
            s3         <= s2;
            period_vld <= 1'b0;
            note_chg   <= 1'b0;
            per_cnt    <= (per_cnt == PER_MAX) ? per_cnt : (per_cnt + 18'd1);
            idle_cnt   <= idle_cnt + 25'd1;

            if (rise) begin
                idle_cnt <= 25'd0;
                armed    <= 1'b1;
                per_cnt  <= 18'd1;
                if (armed) begin
                    period     <= per_cnt;
                    period_vld <= 1'b1;
                end
            end

            if (timeout) begin
                armed     <= 1'b0;
                match_cnt <= 3'd0;
                last_cand <= 3'd0;
                if (note_code != 3'd0) begin
                    note_code <= 3'd0;
                    tone_on   <= 1'b0;
                    note_chg  <= 1'b1;
                end
            end else if (period_vld) begin
                last_cand <= cand;
                match_cnt <= next_match;
                if ((next_match >= STABLE) && (cand != note_code)) begin
                    note_code <= cand;
                    tone_on   <= (cand != 3'd0);
                    note_chg  <= 1'b1;
                end
            end
        end
    end

endmodule
